// File: rtl/msx_slot_ctrl_if.sv
// CPU-side memory/I/O bus between the T80 and the MSX slot controller.
`timescale 1ns/1ps
interface msx_slot_ctrl_if;
  logic [15:0] a;
  logic [7:0]  d_i;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic        m1_n;
  logic        rfrsh_n;
  logic        ppi_n;
  logic        wait_n;
  logic [1:0]  mem_slot;
  logic [1:0]  mem_subslot;
  logic        mem_cs;
  logic [7:0]  d_o;
  logic        d_oe;

  modport master (
    output a, d_i, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfrsh_n, ppi_n,
    input  wait_n, mem_slot, mem_subslot, mem_cs, d_o, d_oe
  );

  modport slave (
    input  a, d_i, mreq_n, iorq_n, rd_n, wr_n, m1_n, rfrsh_n, ppi_n,
    output wait_n, mem_slot, mem_subslot, mem_cs, d_o, d_oe
  );
endinterface

// File: rtl/msx_slot_ctrl.sv
// MSX1 slot controller: primary slot register (port A8h), subslot registers
// (FFFFh of expanded slots), per-page slot resolution and the M1 wait state.
`timescale 1ns/1ps
module msx_slot_ctrl #(
  parameter logic [3:0] EXP_SLOTS = 4'b1000,
  parameter bit         M1_WAIT   = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  msx_slot_ctrl_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pslot_q, pslot_d;
  logic [7:0]  sslot_q [4];
  logic [7:0]  sslot_d [4];
  logic        wr_prev_q, wr_prev_d;

  logic [1:0]  pg;
  logic [1:0]  cur_slot;
  logic [1:0]  p3_slot;
  logic        mem_active;
  logic        sreg_hit;
  logic        port_hit;
  logic        wr_edge;

  // Address decode: page, slot of the page, and register hits
  always_comb begin
    pg         = bus.a[15:14];
    cur_slot   = pslot_q[{pg, 1'b0} +: 2];
    p3_slot    = pslot_q[7:6];
    mem_active = ~bus.mreq_n & bus.rfrsh_n;
    sreg_hit   = (bus.a == 16'hFFFF) & mem_active & EXP_SLOTS[p3_slot];
    port_hit   = ~bus.iorq_n & bus.m1_n & ~bus.ppi_n & (bus.a[1:0] == 2'b00);
    wr_edge    = ~bus.wr_n & wr_prev_q;
  end

  // Register updates: one write per falling wr_n seen on a ce cycle
  always_comb begin
    pslot_d   = pslot_q;
    wr_prev_d = wr_prev_q;
    for (int unsigned i = 0; i < 4; i++) begin
      sslot_d[i] = sslot_q[i];
    end
    if (ce) begin
      wr_prev_d = bus.wr_n;
      if (wr_edge && port_hit) begin
        pslot_d = bus.d_i;
      end
      if (wr_edge && sreg_hit) begin
        sslot_d[p3_slot] = bus.d_i;
      end
    end
  end

  // Slot/subslot registers and write-edge tracker
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pslot_q   <= '0;
      wr_prev_q <= 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
        sslot_q[i] <= '0;
      end
    end else begin
      pslot_q   <= pslot_d;
      wr_prev_q <= wr_prev_d;
      for (int unsigned i = 0; i < 4; i++) begin
        sslot_q[i] <= sslot_d[i];
      end
    end
  end

  // Memory mapping outputs and register readback
  always_comb begin
    bus.mem_slot    = cur_slot;
    bus.mem_subslot = EXP_SLOTS[cur_slot] ? sslot_q[cur_slot][{pg, 1'b0} +: 2] : 2'b00;
    bus.mem_cs      = mem_active & ~sreg_hit;
    bus.d_o         = '0;
    bus.d_oe        = 1'b0;
    if (~bus.rd_n) begin
      if (port_hit) begin
        bus.d_o  = pslot_q;
        bus.d_oe = 1'b1;
      end else if (sreg_hit) begin
        // MSX subslot register reads back inverted
        bus.d_o  = ~sslot_q[p3_slot];
        bus.d_oe = 1'b1;
      end
    end
  end

  // M1 wait FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // M1 wait FSM: next state, advancing only on ce
  always_comb begin
    state_d = state_q;
    if (!M1_WAIT) begin
      state_d = ST_IDLE;
    end else if (ce) begin
      case (state_q)
        ST_IDLE: if (~bus.m1_n & ~bus.mreq_n) state_d = ST_WAIT;
        ST_WAIT: state_d = ST_HOLD;
        ST_HOLD: if (bus.mreq_n) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // M1 wait FSM: wait_n is low for the single ce period spent in WAIT
  always_comb begin
    bus.wait_n = 1'b1;
    if (state_q == ST_WAIT) begin
      bus.wait_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_msx_slot_ctrl.sv
`timescale 1ns/1ps
module tb_msx_slot_ctrl;

  localparam logic [3:0] TB_EXP = 4'b1000;

  typedef enum int { K_IDLE, K_MRD, K_MWR, K_IORD, K_IOWR, K_RFSH, K_M1, K_INTA } kind_t;

  typedef struct {
    kind_t       k;
    logic [15:0] a;
    logic [7:0]  d;
    logic        ppi;
    logic [1:0]  slot;
    logic [1:0]  sub;
    logic        cs;
    logic        oe;
    logic [7:0]  dout;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0;
  logic [15:0] a = '0;
  logic [7:0]  d_i = '0;
  logic        mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic        m1_n = 1'b1, rfrsh_n = 1'b1, ppi_n = 1'b1;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_pslot;
  int m_sslot [4];
  bit m_prev_wr;
  int m_wait_left;
  bit m_m1_served;

  msx_slot_ctrl_if ifa();
  msx_slot_ctrl_if ifb();

  assign ifa.a = a;       assign ifb.a = a;
  assign ifa.d_i = d_i;   assign ifb.d_i = d_i;
  assign ifa.mreq_n = mreq_n;   assign ifb.mreq_n = mreq_n;
  assign ifa.iorq_n = iorq_n;   assign ifb.iorq_n = iorq_n;
  assign ifa.rd_n = rd_n;       assign ifb.rd_n = rd_n;
  assign ifa.wr_n = wr_n;       assign ifb.wr_n = wr_n;
  assign ifa.m1_n = m1_n;       assign ifb.m1_n = m1_n;
  assign ifa.rfrsh_n = rfrsh_n; assign ifb.rfrsh_n = rfrsh_n;
  assign ifa.ppi_n = ppi_n;     assign ifb.ppi_n = ppi_n;

  msx_slot_ctrl #(.EXP_SLOTS(4'b1000), .M1_WAIT(1'b1)) dut (
    .clk(clk), .reset(reset), .ce(ce), .bus(ifa)
  );

  msx_slot_ctrl #(.EXP_SLOTS(4'b1000), .M1_WAIT(1'b0)) dut_nowait (
    .clk(clk), .reset(reset), .ce(ce), .bus(ifb)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(input kind_t k, input logic [15:0] addr, input logic [7:0] data, input logic ppi);
    a = addr; d_i = data; ppi_n = ppi; ce = 1'b1;
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1; rfrsh_n = 1'b1;
    case (k)
      K_MRD:  begin mreq_n = 1'b0; rd_n = 1'b0; end
      K_MWR:  begin mreq_n = 1'b0; wr_n = 1'b0; end
      K_IORD: begin iorq_n = 1'b0; rd_n = 1'b0; end
      K_IOWR: begin iorq_n = 1'b0; wr_n = 1'b0; end
      K_RFSH: begin mreq_n = 1'b0; rfrsh_n = 1'b0; end
      K_M1:   begin mreq_n = 1'b0; rd_n = 1'b0; m1_n = 1'b0; end
      K_INTA: begin iorq_n = 1'b0; m1_n = 1'b0; end
      default: ;
    endcase
  endtask

  task automatic idle();
    drive(K_IDLE, 16'h0000, 8'h00, 1'b1);
  endtask

  // advance one clock; inputs change 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wait(input string name, input logic exp);
    chk(name, {15'd0, ifa.wait_n}, {15'd0, exp});
    chk({name, "_nw"}, {15'd0, ifb.wait_n}, 16'd1);
  endtask

  function automatic vec_t v(input kind_t k, input logic [15:0] addr, input logic [7:0] data,
                             input logic ppi, input logic [1:0] slot, input logic [1:0] sub,
                             input logic cs, input logic oe, input logic [7:0] dout);
    vec_t r;
    r.k = k; r.a = addr; r.d = data; r.ppi = ppi; r.slot = slot; r.sub = sub;
    r.cs = cs; r.oe = oe; r.dout = dout;
    return r;
  endfunction

  function automatic int slot_of_page(input int ps, input int page);
    return (ps >> (2 * page)) % 4;
  endfunction

  // compare DUT outputs against what the reference model predicts now
  task automatic model_check(input int n);
    int  page, slot, sub, dexp;
    bit  memacc, sreg, port, oe;
    page   = int'(a) / 16384;
    slot   = slot_of_page(m_pslot, page);
    sub    = TB_EXP[slot] ? (m_sslot[slot] >> (2 * page)) % 4 : 0;
    memacc = !mreq_n && rfrsh_n;
    sreg   = memacc && (a == 16'hFFFF) && TB_EXP[m_pslot / 64];
    port   = !iorq_n && m1_n && !ppi_n && (int'(a) % 4 == 0);
    oe     = !rd_n && (port || sreg);
    dexp   = 0;
    if (!rd_n && port) dexp = m_pslot;
    else if (!rd_n && sreg) dexp = 255 - m_sslot[m_pslot / 64];
    chk($sformatf("rnd%0d_slot", n), {14'd0, ifa.mem_slot}, 16'(slot));
    chk($sformatf("rnd%0d_sub", n), {14'd0, ifa.mem_subslot}, 16'(sub));
    chk($sformatf("rnd%0d_cs", n), {15'd0, ifa.mem_cs}, {15'd0, memacc && !sreg});
    chk($sformatf("rnd%0d_oe", n), {15'd0, ifa.d_oe}, {15'd0, oe});
    chk($sformatf("rnd%0d_do", n), {8'd0, ifa.d_o}, 16'(dexp));
    chk($sformatf("rnd%0d_wait", n), {15'd0, ifa.wait_n}, {15'd0, m_wait_left == 0});
    chk($sformatf("rnd%0d_nowait", n), {15'd0, ifb.wait_n}, 16'd1);
  endtask

  // apply the clock edge to the reference model
  task automatic model_edge();
    int  idx;
    bit  sreg, port;
    if (!ce) return;
    idx  = m_pslot / 64;
    sreg = !mreq_n && rfrsh_n && (a == 16'hFFFF) && TB_EXP[idx];
    port = !iorq_n && m1_n && !ppi_n && (int'(a) % 4 == 0);
    if (!wr_n && m_prev_wr) begin
      if (port) m_pslot = int'(d_i);
      if (sreg) m_sslot[idx] = int'(d_i);
    end
    m_prev_wr = wr_n;
    if (m_wait_left > 0) begin
      m_wait_left--;
      m_m1_served = 1'b1;
    end else if (m_m1_served) begin
      if (mreq_n) m_m1_served = 1'b0;
    end else if (!m1_n && !mreq_n) begin
      m_wait_left = 1;
    end
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  vec_t vt[$];

  initial begin
    // pslot=00, sslot3=00 after reset
    vt.push_back(v(K_IORD, 16'h00A8, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 8'h00));
    vt.push_back(v(K_MRD,  16'h4000, 8'h00, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 8'h00));
    vt.push_back(v(K_IOWR, 16'h00A8, 8'hE4, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 8'h00));
    vt.push_back(v(K_IORD, 16'h00A8, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 8'hE4));
    vt.push_back(v(K_MRD,  16'h0000, 8'h00, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 8'h00));
    vt.push_back(v(K_MRD,  16'h4000, 8'h00, 1'b1, 2'd1, 2'd0, 1'b1, 1'b0, 8'h00));
    vt.push_back(v(K_MRD,  16'h8000, 8'h00, 1'b1, 2'd2, 2'd0, 1'b1, 1'b0, 8'h00));
    vt.push_back(v(K_MRD,  16'hC000, 8'h00, 1'b1, 2'd3, 2'd0, 1'b1, 1'b0, 8'h00));
    vt.push_back(v(K_IOWR, 16'h00A8, 8'hC0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 8'h00));
    vt.push_back(v(K_MWR,  16'hFFFF, 8'h1B, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0, 8'h00));
    vt.push_back(v(K_MRD,  16'hFFFF, 8'h00, 1'b1, 2'd3, 2'd0, 1'b0, 1'b1, 8'hE4));
    vt.push_back(v(K_MRD,  16'h4000, 8'h00, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 8'h00));
    vt.push_back(v(K_IOWR, 16'h00A8, 8'hFF, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 8'h00));
    vt.push_back(v(K_MRD,  16'h4000, 8'h00, 1'b1, 2'd3, 2'd2, 1'b1, 1'b0, 8'h00));
    vt.push_back(v(K_MRD,  16'h8000, 8'h00, 1'b1, 2'd3, 2'd1, 1'b1, 1'b0, 8'h00));
    vt.push_back(v(K_MRD,  16'hFFFF, 8'h00, 1'b1, 2'd3, 2'd0, 1'b0, 1'b1, 8'hE4));
    vt.push_back(v(K_IOWR, 16'h00A8, 8'h00, 1'b0, 2'd3, 2'd3, 1'b0, 1'b0, 8'h00));
    vt.push_back(v(K_MWR,  16'hFFFF, 8'h55, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 8'h00));
    vt.push_back(v(K_MRD,  16'hFFFF, 8'h00, 1'b1, 2'd0, 2'd0, 1'b1, 1'b0, 8'h00));
    vt.push_back(v(K_IOWR, 16'h00A8, 8'hC0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 8'h00));
    vt.push_back(v(K_MRD,  16'hFFFF, 8'h00, 1'b1, 2'd3, 2'd0, 1'b0, 1'b1, 8'hE4));
    vt.push_back(v(K_RFSH, 16'h0000, 8'h00, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 8'h00));
    vt.push_back(v(K_IORD, 16'h00A9, 8'h00, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 8'h00));
    vt.push_back(v(K_IORD, 16'h00A8, 8'h00, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 8'h00));
    vt.push_back(v(K_RFSH, 16'hFFFF, 8'h00, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0, 8'h00));

    do_reset();
    @(negedge clk);
    chk_wait("reset_wait", 1'b1);
    tick();

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].k, vt[i].a, vt[i].d, vt[i].ppi);
      @(negedge clk);
      chk($sformatf("vec%0d_slot", i), {14'd0, ifa.mem_slot}, {14'd0, vt[i].slot});
      chk($sformatf("vec%0d_sub", i), {14'd0, ifa.mem_subslot}, {14'd0, vt[i].sub});
      chk($sformatf("vec%0d_cs", i), {15'd0, ifa.mem_cs}, {15'd0, vt[i].cs});
      chk($sformatf("vec%0d_oe", i), {15'd0, ifa.d_oe}, {15'd0, vt[i].oe});
      chk($sformatf("vec%0d_do", i), {8'd0, ifa.d_o}, {8'd0, vt[i].dout});
      chk($sformatf("vec%0d_nw_do", i), {8'd0, ifb.d_o}, {8'd0, vt[i].dout});
      chk_wait($sformatf("vec%0d_wait", i), 1'b1);
      tick();
      idle();
      tick();
    end

    // opcode fetch: one ce period of wait, held through ce gaps
    drive(K_M1, 16'h0000, 8'h00, 1'b1);
    @(negedge clk); chk_wait("m1_pre", 1'b1);
    tick();
    @(negedge clk); chk_wait("m1_wait", 1'b0);
    ce = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk); chk_wait($sformatf("m1_cegap%0d", i), 1'b0);
    end
    ce = 1'b1;
    tick();
    @(negedge clk); chk_wait("m1_release", 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk); chk_wait($sformatf("m1_hold%0d", i), 1'b1);
    end
    idle();
    tick();
    drive(K_RFSH, 16'h0000, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk); chk_wait($sformatf("rfsh_nowait%0d", i), 1'b1);
    end
    idle();
    tick();
    drive(K_INTA, 16'h00FF, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk); chk_wait($sformatf("inta_nowait%0d", i), 1'b1);
    end
    idle();
    tick();
    drive(K_M1, 16'h0000, 8'h00, 1'b1);
    tick();
    @(negedge clk); chk_wait("m1_again", 1'b0);
    idle();
    tick();
    tick();

    // wr_n held low over several ce edges writes only once
    drive(K_IOWR, 16'h00A8, 8'h11, 1'b0);
    tick();
    d_i = 8'h22;
    for (int i = 0; i < 3; i++) tick();
    ce = 1'b0;
    tick();
    ce = 1'b1;
    tick();
    drive(K_IORD, 16'h00A8, 8'h00, 1'b0);
    @(negedge clk); chk("held_wr_single", {8'd0, ifa.d_o}, 16'h0011);
    tick();
    idle();
    tick();

    // asynchronous reset in the middle of a wait state
    drive(K_M1, 16'h0000, 8'h00, 1'b1);
    tick();
    @(negedge clk); chk_wait("rstmid_wait", 1'b0);
    reset = 1'b1;
    #1;
    chk_wait("rstmid_async", 1'b1);
    drive(K_IORD, 16'h00A8, 8'h00, 1'b0);
    #1;
    chk("rstmid_pslot", {8'd0, ifa.d_o}, 16'h0000);
    tick();
    reset = 1'b0;
    idle();
    tick();
    drive(K_M1, 16'h0000, 8'h00, 1'b1);
    tick();
    @(negedge clk); chk_wait("rst_m1_wait", 1'b0);
    idle();
    tick();
    tick();
    drive(K_IOWR, 16'h00A8, 8'hC0, 1'b0);
    tick();
    idle();
    tick();
    drive(K_MRD, 16'hFFFF, 8'h00, 1'b1);
    @(negedge clk); chk("rst_sslot_clear", {8'd0, ifa.d_o}, 16'h00FF);
    tick();

    // randomized traffic against the reference model
    do_reset();
    m_pslot = 0;
    for (int i = 0; i < 4; i++) m_sslot[i] = 0;
    m_prev_wr = 1'b1;
    m_wait_left = 0;
    m_m1_served = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      kind_t       k;
      logic [15:0] addr;
      k = kind_t'($urandom_range(0, 7));
      if (k == K_IORD || k == K_IOWR || k == K_INTA)
        addr = {8'h00, 6'h2A, 2'($urandom_range(0, 3))};
      else if ($urandom_range(0, 2) == 0)
        addr = 16'hFFFF;
      else
        addr = 16'($urandom);
      drive(k, addr, 8'($urandom), $urandom_range(0, 3) == 0);
      ce = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      model_check(n);
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
